// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle control FSM for the 32-bit datapath.
// It decodes the opcode latched in DECODE and drives the datapath control
// flags, the data-memory write strobe and the IN/OUT board handshakes.
// This is the only block that advances the PC. flagPC is non-zero in exactly
// one cycle per instruction, which is always that instruction's last cycle.
module control_sequencer #(
    parameter int OP_W     = 6,
    parameter int MEM_WAIT = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            run,
    input  logic [OP_W-1:0] opcode,
    input  logic            flagJB,
    input  logic            in_valid,
    input  logic            out_ack,
    output logic [1:0]      flagPC,
    output logic            flagRF,
    output logic [2:0]      flagMuxRF,
    output logic [1:0]      flagBQ,
    output logic            flagJR,
    output logic            flagLSR,
    output logic            dm_write,
    output logic            in_req,
    output logic            out_valid,
    output logic            halted,
    output logic            illegal_op
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_IN_WAIT,
        S_OUT_WAIT,
        S_HALT
    } state_t;

    typedef enum logic [OP_W-1:0] {
        OP_ALU  = OP_W'('h00),
        OP_LD   = OP_W'('h01),
        OP_ST   = OP_W'('h02),
        OP_LDR  = OP_W'('h03),
        OP_STR  = OP_W'('h04),
        OP_LI   = OP_W'('h05),
        OP_BEQ  = OP_W'('h06),
        OP_BNE  = OP_W'('h07),
        OP_J    = OP_W'('h08),
        OP_JR   = OP_W'('h09),
        OP_IN   = OP_W'('h0A),
        OP_OUT  = OP_W'('h0B),
        OP_NOP  = OP_W'('h0C),
        OP_SKIP = OP_W'('h0D),
        OP_HALT = OP_W'('h3F)
    } op_t;

    // Last value of the MEM counter before a load moves on to WB.
    localparam logic [1:0] MEM_LAST = 2'(MEM_WAIT);

    state_t          state;
    logic [OP_W-1:0] op_q;
    logic [1:0]      mem_cnt;

    // State register, opcode latch and load-wait counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_FETCH;
            op_q    <= '0;
            mem_cnt <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (run) state <= S_DECODE;
                end
                S_DECODE: begin
                    op_q  <= opcode;
                    state <= (opcode == OP_HALT) ? S_HALT : S_EXEC;
                end
                S_EXEC: begin
                    mem_cnt <= '0;
                    case (op_q)
                        OP_ALU:        state <= S_WB;
                        OP_LD, OP_LDR: state <= S_MEM;
                        OP_IN:         state <= S_IN_WAIT;
                        OP_OUT:        state <= S_OUT_WAIT;
                        default:       state <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (mem_cnt == MEM_LAST) begin
                        state <= S_WB;
                    end else begin
                        mem_cnt <= mem_cnt + 2'd1;
                    end
                end
                S_WB: begin
                    state <= S_FETCH;
                end
                S_IN_WAIT: begin
                    if (in_valid) state <= S_FETCH;
                end
                S_OUT_WAIT: begin
                    if (out_ack) state <= S_FETCH;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

    // Control outputs decoded from state and latched opcode.
    // They are forced low while reset is high, so an aborted instruction
    // cannot pulse a write or PC update in the reset cycle.
    always_comb begin
        flagPC     = 2'd0;
        flagRF     = 1'b0;
        flagMuxRF  = 3'd0;
        flagBQ     = 2'd0;
        flagJR     = 1'b0;
        flagLSR    = 1'b0;
        dm_write   = 1'b0;
        in_req     = 1'b0;
        out_valid  = 1'b0;
        halted     = 1'b0;
        illegal_op = 1'b0;
        if (!reset) begin
            case (state)
                S_EXEC: begin
                    case (op_q)
                        OP_ALU, OP_LD, OP_IN, OP_OUT: begin
                        end
                        OP_LDR: begin
                            flagLSR = 1'b1;
                        end
                        OP_ST: begin
                            dm_write = 1'b1;
                            flagPC   = 2'd1;
                        end
                        OP_STR: begin
                            dm_write = 1'b1;
                            flagLSR  = 1'b1;
                            flagPC   = 2'd1;
                        end
                        OP_LI: begin
                            flagRF    = 1'b1;
                            flagMuxRF = 3'd4;
                            flagPC    = 2'd1;
                        end
                        OP_BEQ: begin
                            flagBQ = 2'd1;
                            flagPC = flagJB ? 2'd2 : 2'd1;
                        end
                        OP_BNE: begin
                            flagBQ = 2'd2;
                            flagPC = flagJB ? 2'd2 : 2'd1;
                        end
                        OP_J: begin
                            flagPC = 2'd2;
                        end
                        OP_JR: begin
                            flagJR = 1'b1;
                            flagPC = 2'd2;
                        end
                        OP_NOP: begin
                            flagPC = 2'd1;
                        end
                        OP_SKIP: begin
                            flagPC = 2'd3;
                        end
                        default: begin
                            illegal_op = 1'b1;
                            flagPC     = 2'd1;
                        end
                    endcase
                end
                S_MEM: begin
                    flagLSR = (op_q == OP_LDR);
                end
                S_WB: begin
                    flagRF    = 1'b1;
                    flagMuxRF = (op_q == OP_ALU) ? 3'd1 : 3'd2;
                    flagLSR   = (op_q == OP_LDR);
                    flagPC    = 2'd1;
                end
                S_IN_WAIT: begin
                    if (in_valid) begin
                        flagRF    = 1'b1;
                        flagMuxRF = 3'd3;
                        flagPC    = 2'd1;
                    end else begin
                        in_req = 1'b1;
                    end
                end
                S_OUT_WAIT: begin
                    out_valid = 1'b1;
                    if (out_ack) flagPC = 2'd1;
                end
                S_HALT: begin
                    halted = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed testbench for control_sequencer: per-cycle stimulus tables with
// hand-computed expected output vectors, one task per scenario.
module tb_control_sequencer;

    logic       clock = 1'b0;
    logic       reset, run, flagJB, in_valid, out_ack;
    logic [5:0] opcode;
    logic [1:0] flagPC, flagBQ;
    logic [2:0] flagMuxRF;
    logic       flagRF, flagJR, flagLSR, dm_write, in_req, out_valid, halted, illegal_op;

    int total = 0;
    int bad   = 0;

    control_sequencer #(.OP_W(6), .MEM_WAIT(1)) dut (
        .clock(clock), .reset(reset), .run(run), .opcode(opcode),
        .flagJB(flagJB), .in_valid(in_valid), .out_ack(out_ack),
        .flagPC(flagPC), .flagRF(flagRF), .flagMuxRF(flagMuxRF), .flagBQ(flagBQ),
        .flagJR(flagJR), .flagLSR(flagLSR), .dm_write(dm_write), .in_req(in_req),
        .out_valid(out_valid), .halted(halted), .illegal_op(illegal_op)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        run;
        logic [5:0]  op;
        logic        jb;
        logic        iv;
        logic        ack;
        logic [14:0] exp;
    } cyc_t;

    // Vector layout: {flagPC, flagRF, flagMuxRF, flagBQ, flagJR, flagLSR,
    //                 dm_write, in_req, out_valid, halted, illegal_op}
    function automatic logic [14:0] ev(input logic [1:0] pc, input logic rf, input logic [2:0] mux,
                                       input logic [1:0] bq, input logic jr, input logic lsr,
                                       input logic dm, input logic ir, input logic ov,
                                       input logic h, input logic il);
        return {pc, rf, mux, bq, jr, lsr, dm, ir, ov, h, il};
    endfunction

    function automatic logic [14:0] outv();
        return {flagPC, flagRF, flagMuxRF, flagBQ, flagJR, flagLSR,
                dm_write, in_req, out_valid, halted, illegal_op};
    endfunction

    function automatic cyc_t cy(input logic r, input logic rn, input logic [5:0] o,
                                input logic jb, input logic iv, input logic ack,
                                input logic [14:0] e);
        cyc_t c;
        c.rst = r; c.run = rn; c.op = o; c.jb = jb; c.iv = iv; c.ack = ack; c.exp = e;
        return c;
    endfunction

    localparam logic [14:0] Z = 15'h0;

    logic [14:0] WB_ALU, WB_LD, WB_LDR, LSR, ST, STR, LI, BEQ_T, BEQ_N, BNE_T, BNE_N;
    logic [14:0] JMP, JR, NOP, SKIP, INREQ, IN_DONE, OV, OUT_DONE, HLT, ILL;

    initial begin
        WB_ALU   = ev(2'd1, 1, 3'd1, 2'd0, 0, 0, 0, 0, 0, 0, 0);
        WB_LD    = ev(2'd1, 1, 3'd2, 2'd0, 0, 0, 0, 0, 0, 0, 0);
        WB_LDR   = ev(2'd1, 1, 3'd2, 2'd0, 0, 1, 0, 0, 0, 0, 0);
        LSR      = ev(2'd0, 0, 3'd0, 2'd0, 0, 1, 0, 0, 0, 0, 0);
        ST       = ev(2'd1, 0, 3'd0, 2'd0, 0, 0, 1, 0, 0, 0, 0);
        STR      = ev(2'd1, 0, 3'd0, 2'd0, 0, 1, 1, 0, 0, 0, 0);
        LI       = ev(2'd1, 1, 3'd4, 2'd0, 0, 0, 0, 0, 0, 0, 0);
        BEQ_T    = ev(2'd2, 0, 3'd0, 2'd1, 0, 0, 0, 0, 0, 0, 0);
        BEQ_N    = ev(2'd1, 0, 3'd0, 2'd1, 0, 0, 0, 0, 0, 0, 0);
        BNE_T    = ev(2'd2, 0, 3'd0, 2'd2, 0, 0, 0, 0, 0, 0, 0);
        BNE_N    = ev(2'd1, 0, 3'd0, 2'd2, 0, 0, 0, 0, 0, 0, 0);
        JMP      = ev(2'd2, 0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
        JR       = ev(2'd2, 0, 3'd0, 2'd0, 1, 0, 0, 0, 0, 0, 0);
        NOP      = ev(2'd1, 0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
        SKIP     = ev(2'd3, 0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
        INREQ    = ev(2'd0, 0, 3'd0, 2'd0, 0, 0, 0, 1, 0, 0, 0);
        IN_DONE  = ev(2'd1, 1, 3'd3, 2'd0, 0, 0, 0, 0, 0, 0, 0);
        OV       = ev(2'd0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 1, 0, 0);
        OUT_DONE = ev(2'd1, 0, 3'd0, 2'd0, 0, 0, 0, 0, 1, 0, 0);
        HLT      = ev(2'd0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 1, 0);
        ILL      = ev(2'd1, 0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 0, 1);
    end

    // Both helpers below only apply stimulus; every test does its own compare.
    task automatic apply(input cyc_t c);
        reset = c.rst; run = c.run; opcode = c.op;
        flagJB = c.jb; in_valid = c.iv; out_ack = c.ack;
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        cyc_t t[$];
        for (int i = 0; i < 3; i++) t.push_back(cy(1, 0, 6'h00, 0, 0, 0, Z));
        t.push_back(cy(0, 0, 6'h00, 0, 0, 0, Z));   // run low: stall in FETCH
        t.push_back(cy(0, 0, 6'h00, 0, 0, 0, Z));
        foreach (t[i]) begin
            apply(t[i]);
            total++;
            if (outv() !== t[i].exp) begin
                bad++; $display("FAIL reset[%0d] got=%h exp=%h", i, outv(), t[i].exp);
            end
            next_cycle();
        end
    endtask

    task automatic test_alu_load();
        cyc_t t[$];
        // ALU: FETCH, DECODE, EXEC, WB
        t.push_back(cy(0, 1, 6'h00, 0, 0, 0, Z));
        t.push_back(cy(0, 1, 6'h00, 0, 0, 0, Z));
        t.push_back(cy(0, 1, 6'h00, 0, 0, 0, Z));
        t.push_back(cy(0, 1, 6'h00, 0, 0, 0, WB_ALU));
        // LD: FETCH, DECODE, EXEC, MEM, MEM, WB
        for (int i = 0; i < 5; i++) t.push_back(cy(0, 1, 6'h01, 0, 0, 0, Z));
        t.push_back(cy(0, 1, 6'h01, 0, 0, 0, WB_LD));
        // LDR: same shape with flagLSR in EXEC, MEM and WB
        t.push_back(cy(0, 1, 6'h03, 0, 0, 0, Z));
        t.push_back(cy(0, 1, 6'h03, 0, 0, 0, Z));
        for (int i = 0; i < 3; i++) t.push_back(cy(0, 1, 6'h03, 0, 0, 0, LSR));
        t.push_back(cy(0, 1, 6'h03, 0, 0, 0, WB_LDR));
        foreach (t[i]) begin
            apply(t[i]);
            total++;
            if (outv() !== t[i].exp) begin
                bad++; $display("FAIL alu_load[%0d] got=%h exp=%h", i, outv(), t[i].exp);
            end
            next_cycle();
        end
    endtask

    task automatic test_store_li();
        cyc_t t[$];
        logic [5:0] ops [3];
        logic [14:0] ex [3];
        ops = '{6'h02, 6'h04, 6'h05};
        ex  = '{ST, STR, LI};
        for (int k = 0; k < 3; k++) begin
            t.push_back(cy(0, 1, ops[k], 0, 0, 0, Z));
            t.push_back(cy(0, 1, ops[k], 0, 0, 0, Z));
            t.push_back(cy(0, 1, ops[k], 0, 0, 0, ex[k]));
        end
        foreach (t[i]) begin
            apply(t[i]);
            total++;
            if (outv() !== t[i].exp) begin
                bad++; $display("FAIL store_li[%0d] got=%h exp=%h", i, outv(), t[i].exp);
            end
            next_cycle();
        end
    endtask

    task automatic test_branch();
        cyc_t t[$];
        logic [5:0] ops [4];
        logic       jbs [4];
        logic [14:0] ex [4];
        ops = '{6'h06, 6'h07, 6'h06, 6'h07};
        jbs = '{1'b1, 1'b0, 1'b0, 1'b1};
        ex  = '{BEQ_T, BNE_N, BEQ_N, BNE_T};
        for (int k = 0; k < 4; k++) begin
            t.push_back(cy(0, 1, ops[k], jbs[k], 0, 0, Z));
            t.push_back(cy(0, 1, ops[k], jbs[k], 0, 0, Z));
            t.push_back(cy(0, 1, ops[k], jbs[k], 0, 0, ex[k]));
        end
        foreach (t[i]) begin
            apply(t[i]);
            total++;
            if (outv() !== t[i].exp) begin
                bad++; $display("FAIL branch[%0d] got=%h exp=%h", i, outv(), t[i].exp);
            end
            next_cycle();
        end
    endtask

    task automatic test_jump_misc();
        cyc_t t[$];
        logic [5:0] ops [5];
        logic [14:0] ex [5];
        ops = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h2A};
        ex  = '{JMP, JR, NOP, SKIP, ILL};
        for (int k = 0; k < 5; k++) begin
            t.push_back(cy(0, 1, ops[k], 1, 0, 0, Z));
            t.push_back(cy(0, 1, ops[k], 1, 0, 0, Z));
            t.push_back(cy(0, 1, ops[k], 1, 0, 0, ex[k]));
        end
        // illegal_op is a single-cycle pulse: back in FETCH with run low
        t.push_back(cy(0, 0, 6'h2A, 0, 0, 0, Z));
        foreach (t[i]) begin
            apply(t[i]);
            total++;
            if (outv() !== t[i].exp) begin
                bad++; $display("FAIL jump_misc[%0d] got=%h exp=%h", i, outv(), t[i].exp);
            end
            next_cycle();
        end
    endtask

    task automatic test_io();
        cyc_t t[$];
        // IN with in_valid low for 5 IN_WAIT cycles, valid on the 6th
        for (int i = 0; i < 3; i++) t.push_back(cy(0, 1, 6'h0A, 0, 0, 0, Z));
        for (int i = 0; i < 5; i++) t.push_back(cy(0, 1, 6'h0A, 0, 0, 0, INREQ));
        t.push_back(cy(0, 1, 6'h0A, 0, 1, 0, IN_DONE));
        // IN with in_valid already high on entry
        for (int i = 0; i < 3; i++) t.push_back(cy(0, 1, 6'h0A, 0, 1, 0, Z));
        t.push_back(cy(0, 1, 6'h0A, 0, 1, 0, IN_DONE));
        // OUT acknowledged after 3 waiting cycles
        for (int i = 0; i < 3; i++) t.push_back(cy(0, 1, 6'h0B, 0, 0, 0, Z));
        for (int i = 0; i < 3; i++) t.push_back(cy(0, 1, 6'h0B, 0, 0, 0, OV));
        t.push_back(cy(0, 1, 6'h0B, 0, 0, 1, OUT_DONE));
        t.push_back(cy(0, 0, 6'h0B, 0, 0, 0, Z));
        foreach (t[i]) begin
            apply(t[i]);
            total++;
            if (outv() !== t[i].exp) begin
                bad++; $display("FAIL io[%0d] got=%h exp=%h", i, outv(), t[i].exp);
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid();
        cyc_t t[$];
        // LD: FETCH, DECODE, EXEC, MEM, then reset during the second MEM cycle
        for (int i = 0; i < 4; i++) t.push_back(cy(0, 1, 6'h01, 0, 0, 0, Z));
        t.push_back(cy(1, 1, 6'h01, 0, 0, 0, Z));
        t.push_back(cy(0, 0, 6'h01, 0, 0, 0, Z));
        t.push_back(cy(0, 0, 6'h01, 0, 0, 0, Z));
        // ALU from FETCH with standard timing proves the abort landed in FETCH
        for (int i = 0; i < 3; i++) t.push_back(cy(0, 1, 6'h00, 0, 0, 0, Z));
        t.push_back(cy(0, 1, 6'h00, 0, 0, 0, WB_ALU));
        // reset during ALU WB suppresses the write in that cycle
        for (int i = 0; i < 3; i++) t.push_back(cy(0, 1, 6'h00, 0, 0, 0, Z));
        t.push_back(cy(1, 1, 6'h00, 0, 0, 0, Z));
        t.push_back(cy(0, 0, 6'h00, 0, 0, 0, Z));
        foreach (t[i]) begin
            apply(t[i]);
            total++;
            if (outv() !== t[i].exp) begin
                bad++; $display("FAIL reset_mid[%0d] got=%h exp=%h", i, outv(), t[i].exp);
            end
            next_cycle();
        end
    endtask

    task automatic test_halt();
        cyc_t t[$];
        t.push_back(cy(0, 1, 6'h3F, 0, 0, 0, Z));
        t.push_back(cy(0, 1, 6'h3F, 0, 0, 0, Z));
        // halted holds while run toggles and other inputs wiggle
        for (int i = 0; i < 6; i++)
            t.push_back(cy(0, i[0], 6'h00, 1, i[1], i[0], HLT));
        t.push_back(cy(1, 1, 6'h00, 0, 0, 0, Z));
        for (int i = 0; i < 3; i++) t.push_back(cy(0, 1, 6'h00, 0, 0, 0, Z));
        t.push_back(cy(0, 1, 6'h00, 0, 0, 0, WB_ALU));
        foreach (t[i]) begin
            apply(t[i]);
            total++;
            if (outv() !== t[i].exp) begin
                bad++; $display("FAIL halt[%0d] got=%h exp=%h", i, outv(), t[i].exp);
            end
            next_cycle();
        end
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; opcode = '0;
        flagJB = 1'b0; in_valid = 1'b0; out_ack = 1'b0;
        next_cycle();
        test_reset();
        test_alu_load();
        test_store_li();
        test_branch();
        test_jump_misc();
        test_io();
        test_reset_mid();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
